pipe_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding unit for the MIPS pipeline, replacing the fixed 2-bit per-register status table in the top level. The unit tracks every in-flight register write from EX through WB in a shift-register scoreboard. It stalls the decode→EX issue on unresolved dependences and supplies registered forwarding selects plus muxed operands to the ALU. Pipeline depth, register count, data width and load-result latency are all parameters.

---
 rtl/pipe_scoreboard.sv | 132 +++++++++++++
 tb/tb_pipe_scoreboard.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
// Hazard-detection / forwarding scoreboard for the MIPS EX..WB pipeline.
// Define PIPE_SB_FWD_EN for forwarding; otherwise the unit is interlock-only.
module pipe_scoreboard #(
  parameter  int XLEN       = 32,
  parameter  int NREG       = 32,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_READY = 2,
  localparam int RAW        = $clog2(NREG),
  localparam int SW         = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [RAW-1:0]        issue_rs,
  input  logic [RAW-1:0]        issue_rt,
  input  logic                  issue_use_rs,
  input  logic                  issue_use_rt,
  input  logic                  issue_wr,
  input  logic [RAW-1:0]        issue_rd,
  input  logic                  issue_is_load,
  input  logic                  flush,
  output logic                  issue_ready,
  input  logic [XLEN-1:0]       rf_a,
  input  logic [XLEN-1:0]       rf_b,
  input  logic [DEPTH*XLEN-1:0] res_data,
  output logic [SW-1:0]         fwd_a_sel,
  output logic [SW-1:0]         fwd_b_sel,
  output logic [XLEN-1:0]       op_a,
  output logic [XLEN-1:0]       op_b,
  output logic [15:0]           stall_cnt
);

  logic [DEPTH-1:0] sb_vld;
  logic [DEPTH-1:0] sb_ld;
  logic [RAW-1:0]   sb_rd [DEPTH];

  logic          hit_a, hit_b, ld_a, ld_b;
  logic [SW-1:0] idx_a, idx_b;
  logic          haz_a, haz_b, take_p0, stall_ev;

  // First stage at which a producer's result can be consumed.
  function automatic int ready_stage(input logic ld);
`ifdef PIPE_SB_FWD_EN
    return ld ? LOAD_READY : 1;
`else
    return ld ? DEPTH : DEPTH;
`endif
  endfunction

  function automatic logic hazard_of(input logic hit, input logic [SW-1:0] idx,
                                     input logic ld);
    return hit && (int'(idx) + 1 < ready_stage(ld));
  endfunction

  function automatic logic [SW-1:0] sel_of(input logic hit, input logic [SW-1:0] idx);
    // The producer advances one stage while the consumer moves into EX.
    if (hit && int'(idx) < DEPTH - 1) return idx + SW'(2);
    return '0;
  endfunction

  // Decode stage: youngest matching in-flight writer per source
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    idx_a = '0;
    idx_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (issue_use_rs && issue_rs != '0 && sb_vld[k] && sb_rd[k] == issue_rs) begin
        hit_a = 1'b1;
        idx_a = SW'(k);
        ld_a  = sb_ld[k];
      end
      if (issue_use_rt && issue_rt != '0 && sb_vld[k] && sb_rd[k] == issue_rt) begin
        hit_b = 1'b1;
        idx_b = SW'(k);
        ld_b  = sb_ld[k];
      end
    end
  end

  assign haz_a       = hazard_of(hit_a, idx_a, ld_a);
  assign haz_b       = hazard_of(hit_b, idx_b, ld_b);
  assign issue_ready = ~(issue_valid & (haz_a | haz_b));
  assign take_p0     = issue_valid & issue_ready & ~flush;
  assign stall_ev    = issue_valid & ~issue_ready & ~flush;

  // EX..WB scoreboard shift: control with reset, register tags without
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_vld    <= '0;
      stall_cnt <= '0;
    end else begin
      sb_vld <= {sb_vld[DEPTH-2:0], take_p0 & issue_wr & (issue_rd != '0)};
      if (stall_ev && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    sb_rd[0] <= issue_rd;
    sb_ld    <= {sb_ld[DEPTH-2:0], issue_is_load};
    for (int k = 1; k < DEPTH; k++) sb_rd[k] <= sb_rd[k-1];
  end

`ifdef PIPE_SB_FWD_EN
  // EX stage: forwarding selects registered at issue
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_a_sel <= '0;
      fwd_b_sel <= '0;
    end else begin
      fwd_a_sel <= take_p0 ? sel_of(hit_a, idx_a) : '0;
      fwd_b_sel <= take_p0 ? sel_of(hit_b, idx_b) : '0;
    end
  end
`else
  assign fwd_a_sel = '0;
  assign fwd_b_sel = '0;
`endif

  // EX stage: operand muxes
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    for (int s = 1; s <= DEPTH; s++) begin
      if (fwd_a_sel == SW'(s)) op_a = res_data[(s-1)*XLEN +: XLEN];
      if (fwd_b_sel == SW'(s)) op_b = res_data[(s-1)*XLEN +: XLEN];
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Randomized + directed bench for pipe_scoreboard against an issue-history model.
module tb_pipe_scoreboard;
  localparam int XLEN  = 32;
  localparam int DEPTH = 3;
  localparam int LR    = 2;
  localparam int MAXC  = 8192;
  localparam int SD    = 32;
`ifdef PIPE_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  reset, issue_valid, issue_use_rs, issue_use_rt, issue_wr;
  logic                  issue_is_load, flush, issue_ready;
  logic [4:0]            issue_rs, issue_rt, issue_rd;
  logic [XLEN-1:0]       rf_a, rf_b, op_a, op_b;
  logic [DEPTH*XLEN-1:0] res_data;
  logic [1:0]            fwd_a_sel, fwd_b_sel;
  logic [15:0]           stall_cnt;

  pipe_scoreboard #(.XLEN(XLEN), .NREG(32), .DEPTH(DEPTH), .LOAD_READY(LR)) u_dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_use_rs(issue_use_rs),
    .issue_use_rt(issue_use_rt), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .flush(flush), .issue_ready(issue_ready),
    .rf_a(rf_a), .rf_b(rf_b), .res_data(res_data), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .op_a(op_a), .op_b(op_b), .stall_cnt(stall_cnt));

  // Deep instance used only to reach stall-counter saturation quickly.
  logic               s_reset, s_ready;
  logic [XLEN-1:0]    s_op_a, s_op_b;
  logic [5:0]         s_sel_a, s_sel_b;
  logic [15:0]        s_cnt;
  logic [SD*XLEN-1:0] s_res = '0;

  pipe_scoreboard #(.XLEN(XLEN), .NREG(32), .DEPTH(SD), .LOAD_READY(SD-1)) u_sat (
    .clock(clock), .reset(s_reset), .issue_valid(1'b1),
    .issue_rs(5'd1), .issue_rt(5'd0), .issue_use_rs(1'b1),
    .issue_use_rt(1'b0), .issue_wr(1'b1), .issue_rd(5'd1),
    .issue_is_load(1'b1), .flush(1'b0), .issue_ready(s_ready),
    .rf_a(32'h0), .rf_b(32'h0), .res_data(s_res), .fwd_a_sel(s_sel_a),
    .fwd_b_sel(s_sel_b), .op_a(s_op_a), .op_b(s_op_b), .stall_cnt(s_cnt));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: history of what was issued at each clock edge.
  int         n = 0;
  int         rst_edge = 0;
  bit         armed = 1'b0;
  bit         h_wr [MAXC];
  logic [4:0] h_rd [MAXC];
  bit         h_ld [MAXC];
  int         m_sel_a = 0, m_sel_b = 0, m_cnt = 0;

  function automatic void youngest(input logic [4:0] src, input bit use_it,
                                   output bit found, output int k, output bit ld);
    found = 1'b0; k = 0; ld = 1'b0;
    if (use_it && src != 5'd0)
      for (int e = n; e > n - DEPTH && e > rst_edge; e--)
        if (!found && h_wr[e] && h_rd[e] == src) begin
          found = 1'b1; k = n - e; ld = h_ld[e];
        end
  endfunction

  function automatic bit m_hazard(input bit found, input int k, input bit ld);
    if (FWD) return found && ld && (k + 1 < LR);
    return found && (k < DEPTH - 1);
  endfunction

  function automatic int m_sel(input bit found, input int k);
    if (FWD && found && k < DEPTH - 1) return k + 2;
    return 0;
  endfunction

  function automatic logic [XLEN-1:0] m_op(input logic [XLEN-1:0] rf, input int sel);
    if (sel == 0) return rf;
    return res_data[(sel-1)*XLEN +: XLEN];
  endfunction

  task automatic step(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                      input bit urs, input bit urt, input bit wr, input logic [4:0] rd,
                      input bit ld, input bit fl, input bit rst, output bit took);
    bit fa, fb, la, lb, exp_ready;
    int ka, kb;
    @(negedge clock);
    issue_valid = v; issue_rs = rs; issue_rt = rt; issue_use_rs = urs;
    issue_use_rt = urt; issue_wr = wr; issue_rd = rd; issue_is_load = ld;
    flush = fl; reset = rst;
    rf_a = $urandom; rf_b = $urandom;
    res_data = {$urandom, $urandom, $urandom};
    #1;
    youngest(rs, urs, fa, ka, la);
    youngest(rt, urt, fb, kb, lb);
    exp_ready = !(v && (m_hazard(fa, ka, la) || m_hazard(fb, kb, lb)));
    if (armed) begin
      chk("issue_ready", issue_ready, exp_ready);
      chk("fwd_a_sel", fwd_a_sel, m_sel_a);
      chk("fwd_b_sel", fwd_b_sel, m_sel_b);
      chk("op_a", op_a, m_op(rf_a, m_sel_a));
      chk("op_b", op_b, m_op(rf_b, m_sel_b));
      chk("stall_cnt", stall_cnt, m_cnt);
    end
    @(posedge clock);
    n++;
    if (rst) begin
      m_cnt = 0; m_sel_a = 0; m_sel_b = 0; rst_edge = n; h_wr[n] = 1'b0;
      took = 1'b0; armed = 1'b1;
    end else begin
      took = v && exp_ready && !fl;
      h_wr[n] = took && wr && rd != 5'd0;
      h_rd[n] = rd;
      h_ld[n] = ld;
      m_sel_a = took ? m_sel(fa, ka) : 0;
      m_sel_b = took ? m_sel(fb, kb) : 0;
      if (v && !exp_ready && !fl && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input bit urs, input bit urt, input bit wr, input bit ld);
    bit t;
    step(1'b1, rs, rt, urs, urt, wr, rd, ld, 1'b0, 1'b0, t);
  endtask

  task automatic do_reset();
    bit t;
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, t);
  endtask

  task automatic issue_until(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input bit urs, input bit urt, input bit wr, input bit ld);
    bit t = 1'b0;
    for (int i = 0; i < 8 && !t; i++)
      step(1'b1, rs, rt, urs, urt, wr, rd, ld, 1'b0, 1'b0, t);
    chk("issue_accepted", t, 1'b1);
  endtask

  bit         r_v, r_urs, r_urt, r_wr, r_ld, r_fl, r_rst, r_t;
  logic [4:0] r_rs, r_rt, r_rd;

  initial begin
    s_reset = 1'b1;
    do_reset();
    do_reset();

    // Reset state, operand passthrough
    @(negedge clock);
    issue_valid = 1'b0; reset = 1'b0; flush = 1'b0; rf_a = 32'h1234;
    #1;
    chk("rst_op_a", op_a, 32'h1234);
    chk("rst_ready", issue_ready, 1'b1);
    chk("rst_sel_a", fwd_a_sel, 0);
    chk("rst_sel_b", fwd_b_sel, 0);
    chk("rst_cnt", stall_cnt, 0);
    @(posedge clock);
    n++; h_wr[n] = 1'b0;

`ifdef PIPE_SB_FWD_EN
    do_reset();
    ins(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    ins(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    chk("t2_sel_a", fwd_a_sel, 2);
    chk("t2_op_a", op_a, res_data[63:32]);
    chk("t2_cnt", stall_cnt, 0);

    do_reset();
    ins(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    issue_until(5'd0, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    chk("t3_cnt", stall_cnt, 1);
    chk("t3_sel_b", fwd_b_sel, 3);
    chk("t3_op_b", op_b, res_data[95:64]);

    do_reset();
    ins(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    ins(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    chk("t4_sel_a", fwd_a_sel, 3);
    chk("t4_cnt", stall_cnt, 0);
    ins(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    ins(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    chk("t4_sel_rf", fwd_a_sel, 0);

    do_reset();
    ins(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, r_t);
    #2;
    chk("t5_flush_cnt", stall_cnt, 0);
    chk("t5_flush_sel", fwd_a_sel, 0);
    ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    ins(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    chk("t5_r0_cnt", stall_cnt, 0);
    chk("t5_r0_sel", fwd_a_sel, 0);
`else
    do_reset();
    ins(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    issue_until(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    chk("t6_cnt", stall_cnt, 2);
    chk("t6_sel_a", fwd_a_sel, 0);
    chk("t6_op_a", op_a, rf_a);
`endif

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 2500; i++) begin
      r_v   = ($urandom_range(0, 9) < 8);
      r_rs  = 5'($urandom_range(0, 3));
      r_rt  = 5'($urandom_range(0, 3));
      r_rd  = 5'($urandom_range(0, 3));
      r_urs = 1'($urandom_range(0, 1));
      r_urt = 1'($urandom_range(0, 1));
      r_wr  = ($urandom_range(0, 3) != 0);
      r_ld  = ($urandom_range(0, 9) < 3);
      r_fl  = ($urandom_range(0, 9) == 0);
      r_rst = ($urandom_range(0, 299) == 0);
      step(r_v, r_rs, r_rt, r_urs, r_urt, r_wr, r_rd, r_ld, r_fl, r_rst, r_t);
    end

    // Saturation on the deep instance: a chain of self-dependent loads
    @(negedge clock);
    issue_valid = 1'b0;
    s_reset = 1'b1;
    @(negedge clock);
    s_reset = 1'b0;
    repeat (32) @(posedge clock);
    #1;
    chk("sat_first", s_cnt, FWD ? 30 : 31);
    repeat (70000) @(posedge clock);
    #1;
    chk("sat_ffff", s_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
